// File: rtl/ddr_wr_burst_avl_bridge.sv
// Turns the FIFO-side wr_burst request/pull/finish handshake into Avalon-MM burst writes.
// Long requests become MAX_BURST-sized sub-bursts; a 2-entry skid buffer hides FIFO read latency and stalls.
module ddr_wr_burst_avl_bridge #(
    parameter int MEM_DATA_BITS   = 64,
    parameter int ADDR_BITS       = 25,
    parameter int MAX_BURST       = 128,
    parameter int BURSTCOUNT_BITS = 8
) (
    input  logic                         mem_clk,
    input  logic                         mem_rst_n,
    input  logic                         wr_burst_req,
    input  logic [9:0]                   wr_burst_len,
    input  logic [ADDR_BITS-1:0]         wr_burst_addr,
    output logic                         wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0]     wr_burst_data,
    output logic                         wr_burst_finish,
    output logic [ADDR_BITS-1:0]         avl_address,
    output logic                         avl_write,
    output logic [MEM_DATA_BITS-1:0]     avl_writedata,
    output logic [MEM_DATA_BITS/8-1:0]   avl_byteenable,
    output logic [BURSTCOUNT_BITS-1:0]   avl_burstcount,
    output logic                         avl_beginbursttransfer,
    input  logic                         avl_waitrequest,
    output logic                         busy,
    output logic [1:0]                   dbg_state_o
);
    // Handshake: an Avalon beat transfers in any cycle with avl_write & !avl_waitrequest.
    // The FIFO side has no backpressure, so a read is issued only when the buffer is sure to have room for it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [9:0] MAX_LEN = 10'(MAX_BURST);

    state_e                       state_q, state_d;
    logic [ADDR_BITS-1:0]         addr_q, addr_d;
    logic [BURSTCOUNT_BITS-1:0]   sub_len_q, sub_len_d;
    logic [BURSTCOUNT_BITS-1:0]   sub_left_q, sub_left_d;
    logic [9:0]                   beat_left_q, beat_left_d;
    logic [9:0]                   rd_left_q, rd_left_d;
    logic                         first_q, first_d;
    logic                         rd_pend_q;

    logic [MEM_DATA_BITS-1:0]     buf_q [2];
    logic                         wr_ptr_q, rd_ptr_q;
    logic [1:0]                   buf_cnt_q;

    logic                         push, accept;
    logic [2:0]                   occ;

    function automatic logic [BURSTCOUNT_BITS-1:0] clip_len(input logic [9:0] n);
        return (n > MAX_LEN) ? BURSTCOUNT_BITS'(MAX_LEN) : BURSTCOUNT_BITS'(n);
    endfunction

    assign push      = rd_pend_q;
    assign avl_write = (buf_cnt_q != 2'd0);
    assign accept    = avl_write & ~avl_waitrequest;

    // Beats held plus beats in flight, minus the one leaving this cycle, must stay at most 1 before a new read.
    assign occ = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q};
    assign wr_burst_data_req = (state_q == S_DATA) && (rd_left_q != 10'd0) &&
                               (occ <= (3'd1 + {2'b00, accept}));

    assign avl_writedata          = buf_q[rd_ptr_q];
    assign avl_address            = addr_q;
    assign avl_burstcount         = sub_len_q;
    assign avl_beginbursttransfer = avl_write & first_q;
    assign avl_byteenable         = '1;
    assign wr_burst_finish        = (state_q == S_DONE);
    assign busy                   = (state_q != S_IDLE);
    assign dbg_state_o            = state_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sub_len_d   = sub_len_q;
        sub_left_d  = sub_left_q;
        beat_left_d = beat_left_q;
        rd_left_d   = rd_left_q;
        first_d     = first_q;
        case (state_q)
            S_IDLE: begin
                if (wr_burst_req) begin
                    addr_d = wr_burst_addr;
                    if (wr_burst_len == 10'd0) begin
                        state_d = S_DONE;
                    end else begin
                        rd_left_d   = wr_burst_len;
                        beat_left_d = wr_burst_len;
                        sub_len_d   = clip_len(wr_burst_len);
                        sub_left_d  = clip_len(wr_burst_len);
                        first_d     = 1'b1;
                        state_d     = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (wr_burst_data_req) begin
                    rd_left_d = rd_left_q - 10'd1;
                end
                if (accept) begin
                    first_d     = 1'b0;
                    beat_left_d = beat_left_q - 10'd1;
                    sub_left_d  = sub_left_q - BURSTCOUNT_BITS'(1);
                    if (beat_left_q == 10'd1) begin
                        state_d = S_DONE;
                    end else if (sub_left_q == BURSTCOUNT_BITS'(1)) begin
                        // Next sub-burst starts right after the one just completed.
                        addr_d     = addr_q + ADDR_BITS'(sub_len_q);
                        sub_len_d  = clip_len(beat_left_q - 10'd1);
                        sub_left_d = clip_len(beat_left_q - 10'd1);
                        first_d    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sub_len_q   <= '0;
            sub_left_q  <= '0;
            beat_left_q <= '0;
            rd_left_q   <= '0;
            first_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            buf_cnt_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sub_len_q   <= sub_len_d;
            sub_left_q  <= sub_left_d;
            beat_left_q <= beat_left_d;
            rd_left_q   <= rd_left_d;
            first_q     <= first_d;
            rd_pend_q   <= wr_burst_data_req;
            if (push) begin
                buf_q[wr_ptr_q] <= wr_burst_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (accept) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            buf_cnt_q <= buf_cnt_q + {1'b0, push} - {1'b0, accept};
        end
    end

    a_no_overflow: assert property (@(posedge mem_clk) disable iff (!mem_rst_n)
        !(push && !accept && (buf_cnt_q == 2'd2)));

endmodule
